// File: rtl/wb_port_if.sv
// Write-back arbiter bus: two requester ports, one registered output port to the
// register file, plus stall counter and round-robin pointer observation.
interface wb_port_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              a_req;
    logic [WIDTH-1:0]  a_data;
    logic [ADDR_W-1:0] a_rd;
    logic              a_gnt;
    logic              b_req;
    logic [WIDTH-1:0]  b_data;
    logic [ADDR_W-1:0] b_rd;
    logic              b_gnt;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [ADDR_W-1:0] out_rd;
    logic              out_sel;
    logic [7:0]        stall_cnt;
    logic              last_grant_dbg;

    // Handshakes: a word moves on a requester port when req && gnt, and leaves the
    // output port when out_valid && out_ready. Requesters hold req/data/rd until gnt;
    // the arbiter holds out_valid/data/rd/sel stable until out_ready.
    modport slave (
        input  a_req, a_data, a_rd, b_req, b_data, b_rd, out_ready,
        output a_gnt, b_gnt, out_valid, out_data, out_rd, out_sel, stall_cnt,
        output last_grant_dbg
    );

    modport master (
        output a_req, a_data, a_rd, b_req, b_data, b_rd, out_ready,
        input  a_gnt, b_gnt, out_valid, out_data, out_rd, out_sel, stall_cnt,
        input  last_grant_dbg
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin 2:1 write-back port arbiter with a one-deep registered output stage
// and a saturating stall counter.
module wb_port_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    wb_port_if.slave bus
);
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_grant_e;

    last_grant_e       last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_sel_q, out_sel_d;
    logic [7:0]        stall_cnt_q, stall_cnt_d;

    logic              can_accept;
    logic              a_win, b_win;
    logic              a_gnt, b_gnt;
    logic [WIDTH-1:0]  win_data;
    logic [ADDR_W-1:0] win_rd;

    // A tie goes to whoever was not granted last; gnt is suppressed during reset.
    always_comb begin
        can_accept = !out_valid_q || bus.out_ready;
        a_win      = bus.a_req && (!bus.b_req || (last_grant_q == LAST_B));
        b_win      = bus.b_req && !a_win;
        a_gnt      = !rst && can_accept && a_win;
        b_gnt      = !rst && can_accept && b_win;
        win_data   = b_gnt ? bus.b_data : bus.a_data;
        win_rd     = b_gnt ? bus.b_rd : bus.a_rd;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_rd_d     = out_rd_q;
        out_sel_d    = out_sel_q;
        stall_cnt_d  = stall_cnt_q;

        if (a_gnt || b_gnt) begin
            last_grant_d = b_gnt ? LAST_B : LAST_A;
            // Writes to register 0 are consumed but never presented downstream.
            if (win_rd != '0) begin
                out_valid_d = 1'b1;
                out_data_d  = win_data;
                out_rd_d    = win_rd;
                out_sel_d   = b_gnt;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && !bus.out_ready && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= LAST_B;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_rd_q     <= '0;
            out_sel_q    <= 1'b0;
            stall_cnt_q  <= 8'd0;
        end else begin
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_rd_q     <= out_rd_d;
            out_sel_q    <= out_sel_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.a_gnt          = a_gnt;
    assign bus.b_gnt          = b_gnt;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_data       = out_data_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_sel        = out_sel_q;
    assign bus.stall_cnt      = stall_cnt_q;
    assign bus.last_grant_dbg = last_grant_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a vector table with a word scoreboard, then hand-written
// stall, saturation and asynchronous-reset sequences.
module tb_wb_port_arbiter;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NVEC   = 14;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    wb_port_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    wb_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              ar;
        logic [ADDR_W-1:0] ard;
        logic [WIDTH-1:0]  ad;
        logic              br;
        logic [ADDR_W-1:0] brd;
        logic [WIDTH-1:0]  bd;
        logic              rdy;
        logic              ag;
        logic              bg;
    } vec_t;

    vec_t vecs [NVEC];
    // Expected output words as {sel, rd, data}.
    logic [WIDTH+ADDR_W:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic ar, input logic [ADDR_W-1:0] ard, input logic [WIDTH-1:0] ad,
                         input logic br, input logic [ADDR_W-1:0] brd, input logic [WIDTH-1:0] bd,
                         input logic rdy);
        bus.a_req     = ar;
        bus.a_rd      = ard;
        bus.a_data    = ad;
        bus.b_req     = br;
        bus.b_rd      = brd;
        bus.b_data    = bd;
        bus.out_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    endtask

    // Called #1 after inputs change: the word shown now leaves at the next edge.
    task automatic sb_accept();
        logic [WIDTH+ADDR_W:0] exp_w;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", {bus.out_sel, bus.out_rd, bus.out_data}, '1);
            end else begin
                exp_w = exp_q.pop_front();
                chk("sb_word", {bus.out_sel, bus.out_rd, bus.out_data}, exp_w);
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;

        //          ar    ard    ad            br    brd    bd            rdy   ag    bg
        vecs[0]  = '{1'b1, 5'd3,  32'h0000_00A0, 1'b1, 5'd4,  32'h0000_00B0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd5,  32'h0000_00A1, 1'b1, 5'd4,  32'h0000_00B0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 5'd5,  32'h0000_00A1, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd5,  32'h0000_00A1, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 5'd7,  32'hAAAA_AAAA, 1'b1, 5'd2,  32'h0000_00B2, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  32'h0000_00B2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  32'h0000_00B2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  32'h0000_00B2, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 5'd9,  32'h0000_00C0, 1'b1, 5'd10, 32'h0000_00D0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 5'd9,  32'h0000_00C0, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b0};

        // Reset holds everything low even with requests pending.
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_a_gnt", bus.a_gnt, 1'b0);
        chk("rst_b_gnt", bus.b_gnt, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_rd", bus.out_rd, '0);
        chk("rst_out_sel", bus.out_sel, 1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 8'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].ar, vecs[i].ard, vecs[i].ad, vecs[i].br, vecs[i].brd, vecs[i].bd,
                  vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_a_gnt", i), bus.a_gnt, vecs[i].ag);
            chk($sformatf("vec%0d_b_gnt", i), bus.b_gnt, vecs[i].bg);
            sb_accept();
            if (vecs[i].ag && vecs[i].ard != '0) exp_q.push_back({1'b0, vecs[i].ard, vecs[i].ad});
            if (vecs[i].bg && vecs[i].brd != '0) exp_q.push_back({1'b1, vecs[i].brd, vecs[i].bd});
            if (i == 4) begin
                @(posedge clk);
                #1;
                chk("rd0_no_valid", bus.out_valid, 1'b0);
                chk("rd0_data_kept", bus.out_data, 32'h0000_00A1);
            end
        end
        @(negedge clk);
        idle();
        #1;
        chk("tbl_out_valid", bus.out_valid, 1'b0);
        chk("tbl_stall_cnt", bus.stall_cnt, 8'd3);
        chk("sb_drained", exp_q.size(), 0);

        // Stall: word held for five refused cycles, competing request not granted.
        reset_pulse();
        @(negedge clk);
        drive(1'b1, 5'd7, 32'hAAAA_AAAA, 1'b0, '0, '0, 1'b0);
        #1;
        chk("stall_first_gnt", bus.a_gnt, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h0000_0066, 1'b0);
            #1;
            chk($sformatf("stall%0d_data", k), bus.out_data, 32'hAAAA_AAAA);
            chk($sformatf("stall%0d_gnt", k), {bus.a_gnt, bus.b_gnt}, 2'b00);
        end
        @(negedge clk);
        #1;
        chk("stall_cnt5", bus.stall_cnt, 8'd5);
        chk("stall_valid_held", bus.out_valid, 1'b1);
        idle();
        @(negedge clk);
        #1;
        chk("stall_release_valid", bus.out_valid, 1'b0);
        chk("stall_cnt_kept", bus.stall_cnt, 8'd5);

        // Saturation over 300 refused cycles.
        reset_pulse();
        @(negedge clk);
        drive(1'b1, 5'd1, 32'h5555_5555, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        repeat (300) @(negedge clk);
        #1;
        chk("sat_stall_cnt", bus.stall_cnt, 8'd255);
        chk("sat_data", bus.out_data, 32'h5555_5555);

        // Asynchronous reset between edges while a word is held.
        drive(1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd3, 32'h0000_0033, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_stall_cnt", bus.stall_cnt, 8'd0);
        chk("async_gnt", {bus.a_gnt, bus.b_gnt}, 2'b00);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_tie_a", {bus.a_gnt, bus.b_gnt}, 2'b10);
        @(negedge clk);
        idle();
        #1;
        chk("post_rst_word", {bus.out_valid, bus.out_sel, bus.out_rd}, {1'b1, 1'b0, 5'd2});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each write-back word.
REQ-002 SHALL have parameter ADDR_W, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port a_req  input  1  requester A has a write-back word pending.
REQ-006 SHALL have port a_data  input  WIDTH  requester A data.
REQ-007 SHALL have port a_rd  input  ADDR_W  requester A destination index.
REQ-008 SHALL have port a_gnt  output  1  requester A word consumed this cycle.
REQ-009 SHALL have ports b_req, b_data, b_rd, b_gnt with the same directions, widths and meanings for requester B.
REQ-010 SHALL have port out_valid  output  1  registered write-back word present.
REQ-011 SHALL have port out_ready  input  1  register-file port accepts word this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  registered winning data (output of the shared 2:1 select).
REQ-013 SHALL have port out_rd  output  ADDR_W  registered winning destination index.
REQ-014 SHALL have port out_sel  output  1  registered source of out_data: 0 = A, 1 = B.
REQ-015 SHALL have port stall_cnt  output  8  saturating count of stall cycles.

Function
REQ-016 SHALL define can_accept = !out_valid || out_ready, evaluated combinationally.
REQ-017 SHALL assert at most one of a_gnt/b_gnt per cycle, combinationally, only when can_accept is 1 and the corresponding req is 1.
REQ-018 SHALL, with only one req high and can_accept 1, grant that requester.
REQ-019 SHALL, with both req high and can_accept 1, grant the requester not granted last (round-robin pointer last_grant, values LAST_A / LAST_B).
REQ-020 SHALL, on each grant, update last_grant to the granted requester at the next edge; pointer unchanged on cycles without a grant.
REQ-021 SHALL, on a grant with rd != 0, load out_data, out_rd, out_sel from the granted requester and set out_valid = 1 at the next edge (req-to-valid latency 1 cycle).
REQ-022 SHALL, on a grant with rd == 0, consume the word (gnt high, pointer updated) but set out_valid = 0 at the next edge and leave out_data/out_rd/out_sel unchanged.
REQ-023 SHALL, with out_valid = 1 and out_ready = 0, hold out_valid, out_data, out_rd, out_sel stable and assert no gnt.
REQ-024 SHALL, with out_valid = 1, out_ready = 1 and no grant, clear out_valid at the next edge.
REQ-025 SHALL sustain one word per cycle when out_ready stays 1 (accept and new grant in the same cycle).
REQ-026 SHALL increment stall_cnt by 1 on each edge where out_valid = 1 and out_ready = 0, saturating at 255 (no wrap); cleared only by reset.
REQ-027 SHALL treat requesters as required to hold req, data, rd stable until gnt; a req dropped before gnt is not granted.

Reset
REQ-028 SHALL, while rst = 1, force out_valid = 0, out_data = 0, out_rd = 0, out_sel = 0, stall_cnt = 0, last_grant = LAST_B, and a_gnt = b_gnt = 0, independent of clk.
REQ-029 SHALL, on rst asserted mid-transfer, discard any held output word; first grant after release follows REQ-019 with A winning a tie.

Verification
REQ-030 Reset release, a_req=b_req=1, a_rd=3, b_rd=4, out_ready=1 -> cycle 0 a_gnt=1; cycle 1 out_valid=1, out_rd=3, out_sel=0, b_gnt=1; cycle 2 out_rd=4, out_sel=1.
REQ-031 a_req=1 a_data=32'hAAAAAAAA a_rd=7, out_ready=0 for 5 cycles after valid -> out_data held 32'hAAAAAAAA, no further gnt, stall_cnt=5; out_ready=1 -> out_valid=0 next edge if no req.
REQ-032 b_req=1 b_rd=0 b_data=32'hFFFFFFFF -> b_gnt=1, out_valid stays 0, out_data unchanged, next tie grants A.
REQ-033 out_ready=0 held 300 cycles with out_valid=1 -> stall_cnt=255, no wrap.
REQ-034 rst pulsed asynchronously (between edges) while out_valid=1 -> out_valid=0 and stall_cnt=0 immediately; after release, tie grants A.
